// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-clock press/release/long-press/repeat
// events plus a held level. One instance per button.
module button_event_gen #(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int CNT_W        = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic press,
  output logic release_p,
  output logic long_press,
  output logic repeat_p,
  output logic held
);

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_TICKS - 1);

  state_t           state;
  logic             btn_q;
  logic [CNT_W-1:0] cnt;
  logic             rise, fall;

  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      btn_q      <= 1'b0;
      cnt        <= '0;
      press      <= 1'b0;
      release_p  <= 1'b0;
      long_press <= 1'b0;
      repeat_p   <= 1'b0;
      held       <= 1'b0;
    end else begin
      btn_q      <= btn;
      press      <= 1'b0;
      release_p  <= 1'b0;
      long_press <= 1'b0;
      repeat_p   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // A tick landing on the rise cycle is deliberately not counted.
          if (rise) begin
            state <= HELD;
            press <= 1'b1;
            held  <= 1'b1;
          end
        end
        HELD, LONG: begin
          // Release takes priority over any threshold tick in the same cycle.
          if (fall) begin
            state     <= IDLE;
            release_p <= 1'b1;
            held      <= 1'b0;
            cnt       <= '0;
          end else if (tick) begin
            if (state == HELD) begin
              if (cnt == LONG_MAX) begin
                state      <= LONG;
                long_press <= 1'b1;
                cnt        <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              if (cnt == REP_MAX) begin
                repeat_p <= 1'b1;
                cnt      <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen: a tick-counting reference model queues
// expected events; a negedge monitor pops and compares them against DUT pulses.
module tb_button_event_gen;
  localparam int LT = 4;
  localparam int RT = 2;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset, tick, btn;
  logic press, release_p, long_press, repeat_p, held;

  always #5 clk = ~clk;

  button_event_gen #(.LONG_TICKS(LT), .REPEAT_TICKS(RT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn(btn),
    .press(press), .release_p(release_p), .long_press(long_press),
    .repeat_p(repeat_p), .held(held)
  );

  typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2, EV_REPEAT = 3} ev_t;
  typedef struct {ev_t kind; int cyc;} ev_s;
  ev_s expq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit m_prev = 0, m_pressed = 0;
  int m_ticks = 0;
  int ph = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: events derived from the number of ticks seen while held.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_prev = 0; m_pressed = 0; m_ticks = 0;
    end else begin
      if (!m_pressed) begin
        if (btn && !m_prev) begin
          m_pressed = 1; m_ticks = 0;
          expq.push_back('{EV_PRESS, cyc});
        end
      end else if (!btn && m_prev) begin
        m_pressed = 0;
        expq.push_back('{EV_RELEASE, cyc});
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == LT)
          expq.push_back('{EV_LONG, cyc});
        else if (m_ticks > LT && (m_ticks - LT) % RT == 0)
          expq.push_back('{EV_REPEAT, cyc});
      end
      m_prev = btn;
    end
  end

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    int npulse, kind;
    ev_s e;
    if (!reset) begin
      npulse = int'(press) + int'(release_p) + int'(long_press) + int'(repeat_p);
      check("held", int'(held), int'(m_pressed));
      if (npulse > 0) begin
        check("pulse_onehot", npulse, 1);
        if (expq.size() == 0) begin
          check("unexpected_pulse", npulse, 0);
        end else begin
          e = expq.pop_front();
          kind = press ? EV_PRESS : release_p ? EV_RELEASE : long_press ? EV_LONG : EV_REPEAT;
          check("event_kind", kind, int'(e.kind));
          check("event_cycle", cyc, e.cyc);
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        check("missed_pulse", npulse, 1);
        void'(expq.pop_front());
      end
    end
  end

  task automatic step(input bit b, input bit t);
    @(negedge clk);
    btn = b; tick = t;
  endtask

  task automatic run(input bit b, input int n);
    repeat (n) begin
      ph++;
      step(b, (ph % 4) == 0);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_press"}, int'(press), 0);
    check({tag, "_release"}, int'(release_p), 0);
    check({tag, "_long"}, int'(long_press), 0);
    check({tag, "_repeat"}, int'(repeat_p), 0);
    check({tag, "_held"}, int'(held), 0);
  endtask

  initial begin
    reset = 1'b1; btn = 1'b0; tick = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_outs_zero("reset");
    reset = 1'b0;
    run(0, 4);

    // Tap shorter than the long threshold
    run(1, 6); run(0, 8);
    // Long hold: long press then repeats
    run(1, 80); run(0, 8);
    // Fall coincides with the 4th tick
    step(1, 0);
    repeat (3) begin repeat (3) step(1, 0); step(1, 1); end
    repeat (3) step(1, 0);
    step(0, 1);
    run(0, 8);
    // Reset while in LONG with button held
    run(1, 24);
    step(1, 0);
    @(posedge clk); #3 reset = 1'b1;
    #1 check_outs_zero("async_reset");
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    run(1, 40); run(0, 8);
    // No ticks at all: press and held only
    repeat (100) step(1, 0);
    run(0, 8);
    // Back-to-back presses, rise coinciding with a tick
    step(1, 1); step(1, 0); step(0, 0); step(0, 0); step(1, 0);
    run(1, 12); run(0, 8);

    // Randomized runs of button level with sparse ticks
    repeat (80) begin
      bit b;
      int len;
      b = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 30);
      repeat (len) step(b, $urandom_range(0, 2) == 0);
    end

    run(0, 10);
    check("queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
